// File: rtl/bus_arbiter8_pkg.sv
// Shared constants, state encoding and slot extraction for the 8-way bus arbiter.
package bus_arbiter8_pkg;

    localparam int N_REQ  = 8;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Slot idx of the flattened request-data bus: bits [16*idx+15 : 16*idx].
    function automatic logic [DATA_W-1:0] get_slot(
        input logic [N_REQ*DATA_W-1:0] bus,
        input int unsigned             idx
    );
        return bus[idx*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/bus_arbiter8_mux.sv
// Plain 8-way 16-bit word multiplexer, selected by a 3-bit index.
module Mux8Way16
    import bus_arbiter8_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] e,
    input  logic [DATA_W-1:0] f,
    input  logic [DATA_W-1:0] g,
    input  logic [DATA_W-1:0] h,
    input  logic [IDX_W-1:0]  sel,
    output logic [DATA_W-1:0] out
);

    always_comb begin
        out = a;
        case (sel)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            3'd7:    out = h;
            default: out = a;
        endcase
    end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter sharing one 16-bit valid/ready output among 8 requesters,
// with bounded bursts per grant and a same-cycle per-requester ack.
module bus_arbiter8
    import bus_arbiter8_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   in_data,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          grant,
    output logic [IDX_W-1:0]          sel,
    output logic                      busy
);

    // Handshake: a word moves when out_valid & out_ready are both high in a
    // cycle; out_valid never waits on out_ready, and ack mirrors that transfer.

    state_e               state_q, state_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [IDX_W-1:0]     last_idx_q, last_idx_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

    logic                 transfer;
    logic [DATA_W-1:0]    mux_out;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 rearb;
    logic [IDX_W-1:0]     search_from;
    logic [IDX_W:0]       win;

    // Returns {found, index}: first set request strictly after 'last',
    // wrapping round so that 'last' itself is checked last.
    function automatic logic [IDX_W:0] rr_search(
        input logic [N_REQ-1:0] r,
        input logic [IDX_W-1:0] last
    );
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = last + IDX_W'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    Mux8Way16 u_mux (
        .a   (get_slot(in_data, 0)),
        .b   (get_slot(in_data, 1)),
        .c   (get_slot(in_data, 2)),
        .d   (get_slot(in_data, 3)),
        .e   (get_slot(in_data, 4)),
        .f   (get_slot(in_data, 5)),
        .g   (get_slot(in_data, 6)),
        .h   (get_slot(in_data, 7)),
        .sel (sel_q),
        .out (mux_out)
    );

    assign busy      = (state_q == ST_BUSY);
    assign out_valid = busy & req[sel_q];
    assign transfer  = out_valid & out_ready;
    assign ack       = transfer ? grant_q : '0;
    assign out_data  = out_valid ? mux_out : '0;
    assign grant     = grant_q;
    assign sel       = sel_q;
    assign cnt_inc   = beat_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        last_idx_d  = last_idx_q;
        beat_cnt_d  = beat_cnt_q;
        rearb       = 1'b0;
        search_from = last_idx_q;
        win         = '0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    rearb = 1'b1;
                end
            end
            ST_BUSY: begin
                if (transfer) begin
                    if ((cnt_inc < CNT_W'(MAX_BURST)) && req[sel_q]) begin
                        beat_cnt_d = cnt_inc;
                    end else begin
                        last_idx_d  = sel_q;
                        search_from = sel_q;
                        rearb       = 1'b1;
                    end
                end else if (!req[sel_q]) begin
                    // Owner withdrew without a transfer: hand over, no ack.
                    last_idx_d  = sel_q;
                    search_from = sel_q;
                    rearb       = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (rearb) begin
            win        = rr_search(req, search_from);
            beat_cnt_d = '0;
            if (win[IDX_W]) begin
                state_d = ST_BUSY;
                sel_d   = win[IDX_W-1:0];
                grant_d = N_REQ'(1) << win[IDX_W-1:0];
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            last_idx_q <= IDX_W'(N_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            last_idx_q <= last_idx_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed bench for bus_arbiter8: one instance with MAX_BURST=1, one with MAX_BURST=4.
module tb_bus_arbiter8;

    logic         clk;
    logic         reset;
    logic [7:0]   req;
    logic [127:0] in_data;
    logic         out_ready;

    logic         v1, v4;
    logic [15:0]  d1, d4;
    logic [7:0]   ack1, ack4, g1, g4;
    logic [2:0]   s1, s4;
    logic         b1, b4;

    int checks = 0;
    int errors = 0;

    bus_arbiter8 #(.MAX_BURST(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .req(req), .in_data(in_data),
        .out_ready(out_ready), .out_valid(v1), .out_data(d1),
        .ack(ack1), .grant(g1), .sel(s1), .busy(b1)
    );

    bus_arbiter8 #(.MAX_BURST(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .req(req), .in_data(in_data),
        .out_ready(out_ready), .out_valid(v4), .out_data(d4),
        .ack(ack4), .grant(g4), .sel(s4), .busy(b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reset across one negedge-to-negedge window with new stimulus applied.
    task automatic do_reset(input logic [7:0] r, input logic rdy);
        @(negedge clk);
        reset     = 1'b1;
        req       = r;
        out_ready = rdy;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    logic [7:0]  exp_g;
    logic [15:0] exp_d;

    initial begin
        reset     = 1'b0;
        req       = 8'hFF;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) in_data[16*i +: 16] = 16'hD000 | 16'(i);
        in_data[16*5 +: 16] = 16'hBEEF;

        // Reset with everything requesting: outputs all low.
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", 16'(v4), 16'h0);
        chk("rst_data", d4, 16'h0);
        chk("rst_ack", 16'(ack4), 16'h0);
        chk("rst_grant", 16'(g4), 16'h0);
        chk("rst_sel", 16'(s4), 16'h0);
        chk("rst_busy", 16'(b4), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("first_grant", 16'(g4), 16'h01);
        chk("first_sel", 16'(s4), 16'h0);
        chk("first_valid", 16'(v4), 16'h1);
        chk("first_busy", 16'(b4), 16'h1);

        // MAX_BURST=1: rotation 0,2,7,... with an ack every cycle.
        do_reset(8'b1000_0101, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            case (i % 3)
                0: begin exp_g = 8'h01; exp_d = 16'hD000; end
                1: begin exp_g = 8'h04; exp_d = 16'hD002; end
                default: begin exp_g = 8'h80; exp_d = 16'hD007; end
            endcase
            chk($sformatf("mb1_grant[%0d]", i), 16'(g1), 16'(exp_g));
            chk($sformatf("mb1_ack[%0d]", i), 16'(ack1), 16'(exp_g));
            chk($sformatf("mb1_data[%0d]", i), d1, exp_d);
        end

        // MAX_BURST=4: four beats on 0, four on 1, back to 0.
        do_reset(8'h03, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step();
            if (i >= 4 && i < 8) begin
                exp_g = 8'h02; exp_d = 16'hD001;
            end else begin
                exp_g = 8'h01; exp_d = 16'hD000;
            end
            chk($sformatf("mb4_ack[%0d]", i), 16'(ack4), 16'(exp_g));
            chk($sformatf("mb4_data[%0d]", i), d4, exp_d);
        end

        // Backpressure on requester 5.
        do_reset(8'h20, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_valid[%0d]", i), 16'(v4), 16'h1);
            chk($sformatf("bp_data[%0d]", i), d4, 16'hBEEF);
            chk($sformatf("bp_ack[%0d]", i), 16'(ack4), 16'h0);
            chk($sformatf("bp_grant[%0d]", i), 16'(g4), 16'h20);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_ack_release", 16'(ack4), 16'h20);
        chk("bp_data_release", d4, 16'hBEEF);
        @(negedge clk);
        req = 8'h00;
        #1;
        chk("bp_ack_after", 16'(ack4), 16'h0);
        step();
        chk("bp_idle_busy", 16'(b4), 16'h0);
        chk("bp_idle_grant", 16'(g4), 16'h0);

        // Withdrawal: owner 3 drops before ack while 6 waits.
        do_reset(8'h08, 1'b0);
        step();
        chk("wd_grant3", 16'(g4), 16'h08);
        chk("wd_valid3", 16'(v4), 16'h1);
        req = 8'h40;
        #1;
        chk("wd_valid_drop", 16'(v4), 16'h0);
        chk("wd_ack_drop", 16'(ack4), 16'h0);
        step();
        chk("wd_grant6", 16'(g4), 16'h40);
        chk("wd_sel6", 16'(s4), 16'h6);
        chk("wd_valid6", 16'(v4), 16'h1);

        // Async reset in the middle of a burst on requester 4.
        do_reset(8'h10, 1'b1);
        step();
        chk("mid_ack0", 16'(ack4), 16'h10);
        step();
        chk("mid_ack1", 16'(ack4), 16'h10);
        step();
        chk("mid_grant_cnt2", 16'(g4), 16'h10);
        req = 8'h11;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_grant", 16'(g4), 16'h0);
        chk("mid_rst_ack", 16'(ack4), 16'h0);
        chk("mid_rst_valid", 16'(v4), 16'h0);
        chk("mid_rst_busy", 16'(b4), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("mid_after_grant", 16'(g4), 16'h01);
        chk("mid_after_ack", 16'(ack4), 16'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter8.md
Name: bus_arbiter8

Overview:
- Round-robin arbiter that shares one 16-bit output bus among 8 requesters.
- Selects each requester's data through the team's 8-way 16-bit mux (Mux8Way16).
- Presents the selected word downstream with a valid/ready handshake and returns a per-requester ack.
- Sits between 8 producer blocks and a single consumer, such as a memory write port or output register.

Parameters:
- MAX_BURST, 4, maximum accepted beats per grant before priority rotates; legal range 1..15.
- CNT_W, 4, width of the beat counter; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  request per requester; bit i = requester i.
- in_data  input  128  flattened data; slot i = bits [16i+15:16i].
- out_ready  input  1  consumer accepts the word this cycle.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  16  selected word; 0 when out_valid is low.
- ack  output  8  one-hot; bit i high in the cycle requester i's word is accepted.
- grant  output  8  one-hot current owner; 0 when idle.
- sel  output  3  index of the current owner; drives the mux select.
- busy  output  1  state is BUSY.

Behaviour:
- Reset (async, immediate): state IDLE, grant=0, sel=0, last_idx=7 (requester 0 highest priority first), beat_cnt=0. Outputs: out_valid=0, out_data=0, ack=0, busy=0.
- Priority search: first i with req[i]=1, scanning from (last_idx+1) mod 8 upward with wrap-around.
- IDLE:
  - If req≠0, at the clock edge: grant the search winner, sel=index, beat_cnt=0, go to BUSY.
  - Latency: req asserted and sampled at edge N → out_valid=1 in cycle N+1.
- BUSY:
  - out_valid = req[sel].
  - out_data = in_data slot sel when out_valid is high, otherwise 0. This path is combinational from in_data.
  - Transfer = out_valid & out_ready. ack[sel] = transfer, combinational, in the same cycle.
- On transfer, at the edge:
  - beat_cnt+1 < MAX_BURST and req[sel] still 1: stay granted, beat_cnt++.
  - Otherwise: last_idx=sel, then re-arbitrate in the same edge. The current owner gets lowest priority.
  - If a winner exists, grant it, beat_cnt=0, stay in BUSY. There is no idle bubble between owners.
  - If no winner, go to IDLE with grant=0.
- Backpressure: with out_ready low, grant, sel, beat_cnt and out_data stay stable and ack=0.
- Protocol: a requester holds req until its ack.
  - If req[sel] drops without a transfer: out_valid falls in the same cycle.
  - At the next edge: last_idx=sel, then re-arbitrate as above. No ack is issued.
- Requests from non-owners never affect the current grant mid-burst.
- grant is always one-hot or zero, and grant[sel]=1 whenever busy=1.
- With MAX_BURST=1, ownership rotates after every beat.

Decomposition:
- Shared package/header holds:
  - constants N_REQ=8 and DATA_W=16;
  - state encodings IDLE=1'b0, BUSY=1'b1;
  - the slot-extraction macro for the 128-bit flattened bus.
- Sub-module: the existing Mux8Way16, fed the 8 slots and sel. Its output is gated by out_valid.
- Priority search stays in this module as a combinational function. No further sub-modules.

Test Plan:
- Reset with req=8'hFF:
  - During reset, all outputs are 0.
  - After deassert, first edge grants 0 (grant=8'h01, sel=0), and out_valid=1 the next cycle.
- MAX_BURST=1, req=8'b1000_0101 held, out_ready=1: grant sequence is 0,2,7,0,2,7, one ack each cycle, no bubble cycles.
- MAX_BURST=4, req=8'h03 held, out_ready=1: four acks on bit 0, then four on bit 1, then back to 0. out_data equals slot 0 or slot 1 contents to match.
- Backpressure with slot 5=16'hBEEF and only req[5]=1:
  - out_ready low for 3 cycles: out_valid=1, out_data=16'hBEEF stable, ack=0.
  - out_ready high: ack=8'h20 for one cycle.
- Withdrawal: owner 3 drops req before ack, while req[6]=1.
  - Same cycle: out_valid=0, ack=0.
  - Next edge: grant=8'h40.
- Async reset mid-burst (beat_cnt=2, owner 4): grant, ack and out_valid clear before the next clock edge. After release, requester 0 again has highest priority.
